// File: rtl/flip_executor.sv
// flip_executor: validates a placed move, flips every bracketed opponent run, then places the mover's piece
module flip_executor #(
  parameter int BOARD_DIM = 8,
  parameter int CELL_W = 2,
  localparam int COORD_W = $clog2(BOARD_DIM)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   move_valid,
  input  logic [COORD_W-1:0]     move_x,
  input  logic [COORD_W-1:0]     move_y,
  input  logic                   player,
  output logic                   busy,
  output logic [2*COORD_W-1:0]   mem_addr,
  output logic                   mem_we,
  output logic [CELL_W-1:0]      mem_wdata,
  input  logic [CELL_W-1:0]      mem_rdata,
  output logic                   next_turn,
  output logic                   illegal_move,
  output logic [4:0]             flip_count
);
  typedef enum logic [3:0] {
    IDLE, CHK_RD, CHK_EV, DIR_INIT, SCAN_RD, SCAN_EV, FLIP, NEXT_DIR, PLACE, DONE, REJECT
  } state_t;
  localparam logic [COORD_W:0] ONE = (COORD_W+1)'(1);
  state_t state;
  logic [COORD_W-1:0] tx, ty;
  logic [COORD_W:0] sx, sy, run, dx, dy, ix, iy, nx, ny, bx, by;
  logic [2:0] dir;
  logic [4:0] acc;
  logic pl, occupied;
  logic [CELL_W-1:0] own, opp;
  assign dx = (dir >= 3'd1 && dir <= 3'd3) ? ONE : (dir >= 3'd5) ? '1 : '0;
  assign dy = (dir == 3'd7 || dir <= 3'd1) ? '1 : (dir >= 3'd3 && dir <= 3'd5) ? ONE : '0;
  assign ix = {1'b0, tx} + dx;
  assign iy = {1'b0, ty} + dy;
  assign nx = sx + dx;
  assign ny = sy + dy;
  assign bx = sx - dx;
  assign by = sy - dy;
  assign own = pl ? CELL_W'(2) : CELL_W'(1);
  assign opp = pl ? CELL_W'(1) : CELL_W'(2);
  assign occupied = mem_rdata == CELL_W'(1) || mem_rdata == CELL_W'(2);
  // move sequencer: check target, scan each direction, flip runs back toward the target, place, report
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      next_turn <= 1'b0;
      illegal_move <= 1'b0;
      flip_count <= '0;
    end else begin
      case (state)
        IDLE: if (move_valid) begin
          tx <= move_x;
          ty <= move_y;
          pl <= player;
          acc <= '0;
          busy <= 1'b1;
          mem_addr <= {move_y, move_x};
          mem_wdata <= player ? CELL_W'(2) : CELL_W'(1);
          state <= CHK_RD;
        end
        CHK_RD: state <= CHK_EV;
        CHK_EV: begin
          dir <= '0;
          illegal_move <= occupied;
          state <= occupied ? REJECT : DIR_INIT;
        end
        DIR_INIT: begin
          sx <= ix;
          sy <= iy;
          run <= '0;
          mem_addr <= {iy[COORD_W-1:0], ix[COORD_W-1:0]};
          state <= (ix[COORD_W] | iy[COORD_W]) ? NEXT_DIR : SCAN_RD;
        end
        SCAN_RD: state <= SCAN_EV;
        SCAN_EV: if (mem_rdata == opp) begin
          run <= run + ONE;
          sx <= nx;
          sy <= ny;
          mem_addr <= {ny[COORD_W-1:0], nx[COORD_W-1:0]};
          state <= (nx[COORD_W] | ny[COORD_W]) ? NEXT_DIR : SCAN_RD;
        end else if (mem_rdata == own && run != '0) begin
          acc <= acc + 5'(run);
          sx <= bx;
          sy <= by;
          mem_addr <= {by[COORD_W-1:0], bx[COORD_W-1:0]};
          mem_we <= 1'b1;
          state <= FLIP;
        end else begin
          state <= NEXT_DIR;
        end
        FLIP: if (run == ONE) begin
          mem_we <= 1'b0;
          state <= NEXT_DIR;
        end else begin
          run <= run - ONE;
          sx <= bx;
          sy <= by;
          mem_addr <= {by[COORD_W-1:0], bx[COORD_W-1:0]};
        end
        NEXT_DIR: if (dir != 3'd7) begin
          dir <= dir + 3'd1;
          state <= DIR_INIT;
        end else if (acc != '0) begin
          mem_addr <= {ty, tx};
          mem_we <= 1'b1;
          state <= PLACE;
        end else begin
          illegal_move <= 1'b1;
          state <= REJECT;
        end
        PLACE: begin
          mem_we <= 1'b0;
          next_turn <= 1'b1;
          flip_count <= acc;
          state <= DONE;
        end
        DONE: begin
          next_turn <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        REJECT: begin
          illegal_move <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
